// File: rtl/tdc_result_serializer.sv
// Captures TDC time_count on each synchronised stop_in rising edge into a small FIFO
// and streams every stored word out as four bytes, LSB first, over valid/ready.
module tdc_result_serializer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stop_in,
   input  logic [31:0]      time_count,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [1:0]       out_idx,
   output logic [PTR_W:0]   fifo_level,
   output logic             overflow,
   input  logic             clr_ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   state_t         state, state_nxt;
   logic           s1, s2, s2_d;
   logic           cap, pop, full, empty, wr_en, drop;
   logic [PTR_W:0] wptr, rptr, level;
   logic [31:0]    mem [DEPTH];
   logic [31:0]    shreg;
   logic [1:0]     idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s2_d <= 1'b0;
      end else begin
         s1   <= stop_in;
         s2   <= s1;
         s2_d <= s2;
      end
   end

   assign cap   = s2 & ~s2_d;
   assign pop   = (state == LOAD);
   assign empty = (wptr == rptr);
   assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                  (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
   // A pop in the same cycle frees the slot, so a capture while full is still accepted.
   assign wr_en = cap & (~full | pop);
   assign drop  = cap & full & ~pop;

   // When full, the write and the LOAD read hit the same slot; the read sees the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem   <= '{default: '0};
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (wr_en) begin
            mem[wptr[PTR_W-1:0]] <= time_count;
            wptr                 <= wptr + PTR_ONE;
         end
         if (pop) begin
            rptr <= rptr + PTR_ONE;
         end
         unique case ({wr_en, pop})
            2'b10:   level <= level + PTR_ONE;
            2'b01:   level <= level - PTR_ONE;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (!empty) state_nxt = LOAD;
         LOAD:    state_nxt = SEND;
         SEND:    if (out_ready && (idx == 2'd3)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         shreg     <= '0;
         idx       <= '0;
      end else begin
         state     <= state_nxt;
         out_valid <= (state_nxt == SEND);
         if (state == LOAD) begin
            shreg <= mem[rptr[PTR_W-1:0]];
            idx   <= '0;
         end else if ((state == SEND) && out_ready) begin
            idx <= idx + 2'd1;
         end
      end
   end

   always_comb begin
      out_data = shreg[7:0];
      unique case (idx)
         2'd0: out_data = shreg[7:0];
         2'd1: out_data = shreg[15:8];
         2'd2: out_data = shreg[23:16];
         2'd3: out_data = shreg[31:24];
         default: out_data = shreg[7:0];
      endcase
   end

   assign out_last   = (idx == 2'd3);
   assign out_idx    = idx;
   assign fifo_level = level;

endmodule

// File: tb/tb_tdc_result_serializer.sv
// Directed bench for tdc_result_serializer: expected beats are queued when a stop edge
// is driven and checked by a byte monitor as the DUT hands them over.
module tb_tdc_result_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stop_in;
   logic [31:0] time_count;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [1:0]  out_idx;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        clr_ovf;

   int n_cmp = 0;
   int n_err = 0;
   logic [10:0] exp_q[$];
   logic        stall_p = 1'b0;
   logic [10:0] held = '0;

   tdc_result_serializer #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .rst(rst), .stop_in(stop_in), .time_count(time_count),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .out_idx(out_idx), .fifo_level(fifo_level),
      .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      logic [10:0] e;
      for (int unsigned b = 0; b < 4; b++) begin
         e = {(b == 3) ? 1'b1 : 1'b0, 2'(b), w[8*b +: 8]};
         exp_q.push_back(e);
      end
   endtask

   task automatic pulse(input logic [31:0] v);
      time_count = v;
      stop_in    = 1'b1;
      repeat (4) step();
      stop_in = 1'b0;
      repeat (3) step();
   endtask

   task automatic wait_drain();
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      check("drain_empty", exp_q.size(), 0);
      step();
      check("idle_after_drain", out_valid, 0);
   endtask

   // Byte monitor: checks hold-stability under backpressure and scoreboard order.
   always @(negedge clk) begin
      if (rst) begin
         stall_p <= 1'b0;
      end else begin
         if (stall_p) begin
            check("hold_valid", out_valid, 1);
            check("hold_beat", {out_last, out_idx, out_data}, held);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
               check("unexpected_beat", {out_last, out_idx, out_data}, 32'hFFFF_FFFF);
            else
               check("beat", {out_last, out_idx, out_data}, exp_q.pop_front());
         end
         stall_p <= out_valid & ~out_ready;
         held    <= {out_last, out_idx, out_data};
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit found;
      rst = 1'b1; stop_in = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; time_count = '0;

      // T1: reset with stop_in toggling
      for (int i = 0; i < 3; i++) begin
         step();
         stop_in = ~stop_in;
         check("t1_valid", out_valid, 0);
         check("t1_level", fifo_level, 0);
         check("t1_ovf", overflow, 0);
      end
      stop_in = 1'b0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         check("t1_no_beat", out_valid, 0);
      end

      // T2: single result, latency from E0
      time_count = 32'hDEADBEEF;
      out_ready  = 1'b1;
      push_word(32'hDEADBEEF);
      stop_in = 1'b1;
      step(); check("t2_valid_e0", out_valid, 0);
      step(); check("t2_valid_e1", out_valid, 0);
      step(); check("t2_level_e2", fifo_level, 1); check("t2_valid_e2", out_valid, 0);
      step(); check("t2_valid_e3", out_valid, 0);
      step(); check("t2_valid_e4", out_valid, 1);
      check("t2_first_byte", out_data, 8'hEF); check("t2_first_idx", out_idx, 0);
      stop_in = 1'b0;
      wait_drain();
      repeat (3) step();

      // T3: backpressure on byte 2
      push_word(32'hDEADBEEF);
      stop_in = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid && out_idx == 2'd2) begin found = 1'b1; break; end
      end
      check("t3_reach_byte2", found, 1);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_hold_data", out_data, 8'hAD);
         check("t3_hold_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      stop_in = 1'b0;
      wait_drain();
      repeat (3) step();

      // T4: overflow
      out_ready = 1'b0;
      for (int v = 1; v <= 5; v++) begin
         push_word(32'(v));
         pulse(32'(v));
      end
      check("t4_level_full", fifo_level, 4);
      check("t4_ovf_clear", overflow, 0);
      check("t4_shifter_busy", out_valid, 1);
      pulse(32'd6);
      check("t4_ovf_set", overflow, 1);
      check("t4_level_kept", fifo_level, 4);
      wait_drain();
      check("t4_ovf_sticky", overflow, 1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("t4_ovf_cleared", overflow, 0);
      repeat (3) step();

      // T5: capture coinciding with LOAD while full
      out_ready = 1'b0;
      for (int v = 'h11; v <= 'h15; v++) begin
         push_word(32'(v));
         pulse(32'(v));
      end
      check("t5_level_full", fifo_level, 4);
      out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid && out_idx == 2'd3) begin found = 1'b1; break; end
      end
      check("t5_reach_last", found, 1);
      time_count = 32'h16;
      stop_in = 1'b1;
      push_word(32'h16);
      step(); check("t5_level_h", fifo_level, 4);
      step(); check("t5_level_load", fifo_level, 4);
      step(); check("t5_level_after", fifo_level, 4);
      check("t5_ovf", overflow, 0);
      stop_in = 1'b0;
      wait_drain();
      check("t5_ovf_end", overflow, 0);
      repeat (3) step();

      // T6: reset mid-word
      push_word(32'hABCD1234);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      out_ready = 1'b1;
      time_count = 32'hABCD1234;
      stop_in = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid && out_idx == 2'd2) begin found = 1'b1; break; end
      end
      check("t6_reach_byte2", found, 1);
      rst = 1'b1;
      stop_in = 1'b0;
      #1;
      check("t6_valid_async", out_valid, 0);
      check("t6_idx_async", out_idx, 0);
      check("t6_level_async", fifo_level, 0);
      repeat (3) step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         check("t6_no_residual", out_valid, 0);
      end
      check("t6_queue_empty", exp_q.size(), 0);
      time_count = 32'hCAFEF00D;
      push_word(32'hCAFEF00D);
      stop_in = 1'b1;
      repeat (4) step();
      stop_in = 1'b0;
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
